// File: rtl/oms_pkg.sv
// Shared definitions for the OMS MAC accumulator: FSM state type, default
// sizing constants and the saturating-add helper used when the
// OMS_ACC_SATURATE_EN build option is enabled.
package oms_pkg;

  localparam int OMS_PROD_W  = 10;
  localparam int OMS_ACC_W   = 13;
  localparam int OMS_N_TERMS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } oms_state_t;

  // Adds a and b and clips at 2^w-1. Result is {overflow, value}; value
  // occupies the low w bits.
  function automatic logic [32:0] oms_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) begin
      return {1'b1, mx[31:0]};
    end
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/oms_acc_datapath.sv
// Accumulator datapath: adder (wrapping, or saturating with sticky flag when
// OMS_ACC_SATURATE_EN is defined), running-sum register and acc_out register.
// Controlled by load/add/capture strobes from the FSM in the top level.
module oms_acc_datapath
  import oms_pkg::*;
#(
  parameter int PROD_W = OMS_PROD_W,
  parameter int ACC_W  = OMS_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              add,
  input  logic              capture,
  input  logic [PROD_W-1:0] mult,
`ifdef OMS_ACC_SATURATE_EN
  output logic              acc_sat,
`endif
  output logic [ACC_W-1:0]  acc_out
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_out_reg;
  logic [ACC_W-1:0] mult_ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
`ifdef OMS_ACC_SATURATE_EN
  logic [32:0]      sat_res;
  logic             ovf;
  logic             sat_reg;
`endif

  // Next sum; mult is gated off unless it is actually consumed so an
  // undriven product bus cannot leak into the registers.
  always_comb begin
    mult_ext = (load || add) ? ACC_W'(mult) : '0;
    base     = load ? '0 : acc_reg;
`ifdef OMS_ACC_SATURATE_EN
    sat_res  = oms_sat_add(32'(base), 32'(mult_ext), ACC_W);
    sum      = ACC_W'(sat_res[31:0]);
    ovf      = sat_res[32];
`else
    sum      = base + mult_ext;
`endif
  end

  // Running sum and published result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg     <= '0;
      acc_out_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else begin
      if (load || add) acc_reg     <= sum;
      if (capture)     acc_out_reg <= sum;
    end
  end

`ifdef OMS_ACC_SATURATE_EN
  // Sticky saturation flag for the batch; restarts with each new batch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_reg <= 1'b0;
    end else if (clr) begin
      sat_reg <= 1'b0;
    end else if (load) begin
      sat_reg <= ovf;
    end else if (add) begin
      sat_reg <= sat_reg | ovf;
    end
  end

  assign acc_sat = sat_reg;
`endif

  assign acc_out = acc_out_reg;

endmodule

// File: rtl/oms_mac_accumulator.sv
// Multiply-accumulate back end for the OMS/APC LUT multiplier: accumulates
// N_TERMS unsigned products per batch and hands each sum out over a
// valid/ready handshake. Build option OMS_ACC_SATURATE_EN turns on
// saturating addition and the acc_sat output.
module oms_mac_accumulator
  import oms_pkg::*;
#(
  parameter int PROD_W  = OMS_PROD_W,
  parameter int ACC_W   = OMS_ACC_W,
  parameter int N_TERMS = OMS_N_TERMS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] mult,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
`ifdef OMS_ACC_SATURATE_EN
  output logic              acc_sat,
`endif
  output logic [7:0]        term_cnt
);

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);
  localparam bit         SINGLE   = (N_TERMS == 1);

  oms_state_t state_reg;
  logic [7:0] term_cnt_reg;
  logic       out_valid_reg;
  logic       accept;
  logic       start;
  logic       load;
  logic       add;
  logic       capture;

  // Handshake and datapath strobes. A HOLD slot frees up in the same cycle
  // it is drained, so back-to-back batches run without a bubble.
  always_comb begin
    in_ready = (state_reg != HOLD) || out_ready;
    accept   = in_valid && in_ready;
    start    = accept && (state_reg != ACCUM);
    load     = !clear && start;
    add      = !clear && accept && (state_reg == ACCUM);
    capture  = (add && (term_cnt_reg == LAST_CNT)) || (load && SINGLE);
  end

  // Batch control FSM; clear outranks accepts and transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      term_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (clear) begin
      state_reg     <= IDLE;
      term_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (start) begin
      term_cnt_reg <= 8'd1;
      if (SINGLE) begin
        state_reg     <= HOLD;
        out_valid_reg <= 1'b1;
      end else begin
        state_reg     <= ACCUM;
        out_valid_reg <= 1'b0;
      end
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            term_cnt_reg <= term_cnt_reg + 8'd1;
            if (term_cnt_reg == LAST_CNT) begin
              state_reg     <= HOLD;
              out_valid_reg <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            term_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          state_reg     <= IDLE;
          term_cnt_reg  <= '0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  oms_acc_datapath #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .clr     (clear),
    .load    (load),
    .add     (add),
    .capture (capture),
    .mult    (mult),
`ifdef OMS_ACC_SATURATE_EN
    .acc_sat (acc_sat),
`endif
    .acc_out (acc_out)
  );

  assign out_valid = out_valid_reg;
  assign term_cnt  = term_cnt_reg;

endmodule

// File: tb/tb_oms_mac_accumulator.sv
// Directed bench for oms_mac_accumulator: default instance (N_TERMS=8,
// ACC_W=13), a narrow ACC_W=10 instance for wrap/saturation and an
// N_TERMS=1 instance for single-term streaming.
module tb_oms_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef OMS_ACC_SATURATE_EN
  localparam int B_EXP = 1023;
`else
  localparam int B_EXP = 576;
`endif

  // Instance A: defaults
  logic        a_clear = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [9:0]  a_mult = '0;
  logic        a_in_ready, a_out_valid;
  logic [12:0] a_acc_out;
  logic [7:0]  a_term_cnt;
  // Instance B: ACC_W=10
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [9:0]  b_mult = '0;
  logic        b_in_ready, b_out_valid;
  logic [9:0]  b_acc_out;
  logic [7:0]  b_term_cnt;
  // Instance C: N_TERMS=1
  logic        c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [9:0]  c_mult = '0;
  logic        c_in_ready, c_out_valid;
  logic [12:0] c_acc_out;
  logic [7:0]  c_term_cnt;
`ifdef OMS_ACC_SATURATE_EN
  logic        a_acc_sat, b_acc_sat, c_acc_sat;
`endif

  oms_mac_accumulator #(.PROD_W(10), .ACC_W(13), .N_TERMS(8)) dut_a (
    .clk(clk), .reset(rst), .clear(a_clear), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mult(a_mult), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .acc_out(a_acc_out),
`ifdef OMS_ACC_SATURATE_EN
    .acc_sat(a_acc_sat),
`endif
    .term_cnt(a_term_cnt));

  oms_mac_accumulator #(.PROD_W(10), .ACC_W(10), .N_TERMS(8)) dut_b (
    .clk(clk), .reset(rst), .clear(1'b0), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mult(b_mult), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .acc_out(b_acc_out),
`ifdef OMS_ACC_SATURATE_EN
    .acc_sat(b_acc_sat),
`endif
    .term_cnt(b_term_cnt));

  oms_mac_accumulator #(.PROD_W(10), .ACC_W(13), .N_TERMS(1)) dut_c (
    .clk(clk), .reset(rst), .clear(1'b0), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .mult(c_mult), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .acc_out(c_acc_out),
`ifdef OMS_ACC_SATURATE_EN
    .acc_sat(c_acc_sat),
`endif
    .term_cnt(c_term_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cyc(input logic v, input logic [9:0] m, input logic r);
    a_in_valid = v; a_mult = m; a_out_ready = r;
    tick();
  endtask

  task automatic b_cyc(input logic v, input logic [9:0] m, input logic r);
    b_in_valid = v; b_mult = m; b_out_ready = r;
    tick();
  endtask

  task automatic c_cyc(input logic v, input logic [9:0] m, input logic r);
    c_in_valid = v; c_mult = m; c_out_ready = r;
    tick();
  endtask

  initial begin
    int stream_vals[4];
    stream_vals = '{11, 961, 0, 42};

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_acc_out",   32'(a_acc_out),   32'd0);
    check("rst_term_cnt",  32'(a_term_cnt),  32'd0);
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
`ifdef OMS_ACC_SATURATE_EN
    check("rst_acc_sat",   32'(b_acc_sat),   32'd0);
`endif
    rst = 1'b0;

    // 8 x 961 with out_ready=1
    for (int k = 1; k <= 7; k++) begin
      a_cyc(1'b1, 10'd961, 1'b1);
      check("max_cnt", 32'(a_term_cnt), 32'(k));
      check("max_novalid", 32'(a_out_valid), 32'd0);
    end
    a_cyc(1'b1, 10'd961, 1'b1);
    check("max_valid", 32'(a_out_valid), 32'd1);
    check("max_sum",   32'(a_acc_out),   32'd7688);
    check("max_cnt8",  32'(a_term_cnt),  32'd8);
    a_cyc(1'b0, 10'd0, 1'b1);
    check("max_pulse_end", 32'(a_out_valid), 32'd0);
    check("max_cnt_clr",   32'(a_term_cnt),  32'd0);

    // Products 1..8, in_valid toggling, downstream stalled
    for (int i = 1; i <= 8; i++) begin
      a_cyc(1'b1, 10'(i), 1'b0);
      check("tog_cnt", 32'(a_term_cnt), 32'(i));
      if (i < 8) begin
        a_cyc(1'b0, 10'h3FF, 1'b0);
        check("tog_cnt_hold", 32'(a_term_cnt), 32'(i));
        check("tog_novalid",  32'(a_out_valid), 32'd0);
      end
    end
    check("tog_valid", 32'(a_out_valid), 32'd1);
    check("tog_sum",   32'(a_acc_out),   32'd36);
    for (int k = 0; k < 5; k++) begin
      a_cyc(1'b0, 10'd0, 1'b0);
      check("stall_valid", 32'(a_out_valid), 32'd1);
      check("stall_sum",   32'(a_acc_out),   32'd36);
      check("stall_ready", 32'(a_in_ready),  32'd0);
    end
    // Transfer and new batch in the same cycle
    a_cyc(1'b1, 10'd5, 1'b1);
    check("b2b_drop_valid", 32'(a_out_valid), 32'd0);
    check("b2b_cnt",        32'(a_term_cnt),  32'd1);
    repeat (7) a_cyc(1'b1, 10'd1, 1'b1);
    check("b2b_valid", 32'(a_out_valid), 32'd1);
    check("b2b_sum",   32'(a_acc_out),   32'd12);
    a_cyc(1'b0, 10'd0, 1'b1);

    // clear after 4 accepts, with a competing accept in the clear cycle
    repeat (4) a_cyc(1'b1, 10'd100, 1'b1);
    check("clr_pre_cnt", 32'(a_term_cnt), 32'd4);
    a_clear = 1'b1;
    a_cyc(1'b1, 10'd100, 1'b1);
    a_clear = 1'b0;
    check("clr_cnt",   32'(a_term_cnt),  32'd0);
    check("clr_valid", 32'(a_out_valid), 32'd0);
    check("clr_ready", 32'(a_in_ready),  32'd1);
    repeat (8) a_cyc(1'b1, 10'd10, 1'b0);
    check("clr_next_valid", 32'(a_out_valid), 32'd1);
    check("clr_next_sum",   32'(a_acc_out),   32'd80);
    // clear drops a pending sum even with out_ready high
    a_clear = 1'b1;
    a_cyc(1'b0, 10'd0, 1'b1);
    a_clear = 1'b0;
    check("clr_hold_valid", 32'(a_out_valid), 32'd0);
    check("clr_hold_cnt",   32'(a_term_cnt),  32'd0);

    // Async reset mid-cycle during ACCUM
    repeat (3) a_cyc(1'b1, 10'd7, 1'b1);
    a_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_cnt",   32'(a_term_cnt),  32'd0);
    check("arst_sum",   32'(a_acc_out),   32'd0);
    check("arst_valid", 32'(a_out_valid), 32'd0);
    check("arst_ready", 32'(a_in_ready),  32'd1);
    #2 rst = 1'b0;
    repeat (8) a_cyc(1'b1, 10'd2, 1'b1);
    check("arst_next_valid", 32'(a_out_valid), 32'd1);
    check("arst_next_sum",   32'(a_acc_out),   32'd16);
    a_cyc(1'b0, 10'd0, 1'b1);

    // ACC_W=10: 8 x 200 wraps or saturates
    repeat (8) b_cyc(1'b1, 10'd200, 1'b1);
    check("narrow_valid", 32'(b_out_valid), 32'd1);
    check("narrow_sum",   32'(b_acc_out),   32'(B_EXP));
`ifdef OMS_ACC_SATURATE_EN
    check("narrow_sat",   32'(b_acc_sat),   32'd1);
`endif
    b_cyc(1'b0, 10'd0, 1'b1);

    // N_TERMS=1: hold with stall, then full-rate streaming
    c_cyc(1'b1, 10'd9, 1'b0);
    check("n1_valid", 32'(c_out_valid), 32'd1);
    check("n1_sum",   32'(c_acc_out),   32'd9);
    check("n1_cnt",   32'(c_term_cnt),  32'd1);
    check("n1_ready", 32'(c_in_ready),  32'd0);
    c_cyc(1'b0, 10'd0, 1'b0);
    check("n1_hold_sum", 32'(c_acc_out), 32'd9);
    for (int k = 0; k < 4; k++) begin
      c_cyc(1'b1, 10'(stream_vals[k]), 1'b1);
      check("n1_stream_valid", 32'(c_out_valid), 32'd1);
      check("n1_stream_sum",   32'(c_acc_out),   32'(stream_vals[k]));
      check("n1_stream_cnt",   32'(c_term_cnt),  32'd1);
    end
    c_cyc(1'b0, 10'd0, 1'b1);
    check("n1_end_valid", 32'(c_out_valid), 32'd0);
    check("n1_end_cnt",   32'(c_term_cnt),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oms_mac_accumulator.md
Name: oms_mac_accumulator

Overview:
- Downstream consumer of the OMS/APC LUT multiplier's 10-bit product bus.
- Accepts one product per cycle over a valid/ready handshake and accumulates N_TERMS products into a running sum.
- Presents each finished sum on an output handshake, so the LUT multiplier becomes a sequential multiply-accumulate (dot-product / FIR tap) engine.
- Products are unsigned: max 31*31 = 961.

Parameters:
- PROD_W, 10, product input width (matches the multiplier output).
- ACC_W, 13, accumulator/result width; the default holds 8*961 = 7688 without overflow.
- N_TERMS, 8, products per accumulation batch; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort: discards the batch in progress.
- in_valid  input  1  mult carries a valid product.
- in_ready  output  1  block can accept a product this cycle.
- mult  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  acc_out holds a completed batch sum.
- out_ready  input  1  downstream accepts acc_out.
- acc_out  output  ACC_W  batch sum.
- term_cnt  output  8  number of products accepted in the current batch.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. While reset is asserted: state=IDLE, accumulator=0, term_cnt=0, out_valid=0, acc_out=0. in_ready is combinational and evaluates to 1 in IDLE.
- Accept event: in_valid && in_ready, sampled at the rising edge.
- Output transfer: out_valid && out_ready.
- in_ready = (state != HOLD) || out_ready. This allows back-to-back batches with zero bubble.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, on accept:
  - accumulator <= zero-extended mult; term_cnt <= 1.
  - Next state is HOLD if N_TERMS==1, otherwise ACCUM.
- ACCUM, on accept:
  - accumulator <= accumulator + mult; term_cnt <= term_cnt + 1.
  - When term_cnt == N_TERMS-1: the sum is written to acc_out, out_valid <= 1, state -> HOLD.
  - No accept: all registers hold.
- HOLD:
  - acc_out and out_valid are stable until transferred.
  - Transfer with no simultaneous accept: out_valid <= 0, term_cnt <= 0, state -> IDLE.
  - Transfer with simultaneous accept: behaves as the IDLE accept (new batch starts, out_valid drops unless N_TERMS==1, in which case out_valid stays 1 with the new sum).
- Latency: acc_out is valid the cycle after the N_TERMS-th accept.
- Arithmetic: unsigned; mult is zero-extended to ACC_W. Without the optional feature, sums wrap modulo 2^ACC_W.
- clear: synchronous, has priority over any accept and any transfer in the same cycle. Effect: state -> IDLE, accumulator=0, term_cnt=0, out_valid=0. A sum pending in HOLD is dropped.
- Reset mid-batch: partial sum is lost; no output is produced.
- mult is ignored whenever no accept occurs; X on mult in that case must not propagate.

Optional Feature:
- Macro: OMS_ACC_SATURATE_EN.
- Defined: each addition saturates at 2^ACC_W-1, and a sticky sat flag is exposed as an extra 1-bit output port acc_sat. acc_sat is cleared by reset, clear, or the start of a new batch, and is valid alongside acc_out.
- Undefined: modular wrap; the acc_sat port is absent.

Decomposition:
- Shared package oms_pkg:
  - FSM state enum type (IDLE/ACCUM/HOLD).
  - Default constants PROD_W=10, ACC_W=13, N_TERMS=8.
  - Function for the saturating add.
- One natural sub-module, oms_acc_datapath: adder, optional saturation logic, accumulator and acc_out registers, driven by load/add/capture strobes from the FSM.

Test Plan:
- reset, then 8 accepts of mult=961 with out_ready=1 -> out_valid pulses for 1 cycle with acc_out=7688, one cycle after the 8th accept; term_cnt is 8 at the pulse.
- Products 1..8 with in_valid toggling every other cycle -> acc_out=36; term_cnt holds on idle cycles.
- Batch completes with out_ready=0 for 5 cycles -> acc_out stays 36 and in_ready=0. Then out_ready=1 together with in_valid and mult=5 -> transfer and new batch in the same cycle; the next sum includes 5.
- clear asserted after 4 accepts of 100 -> IDLE, term_cnt=0, no out_valid. The next 8 accepts of 10 give acc_out=80.
- ACC_W=10, 8 products of 200:
  - Without the macro: acc_out=1600 mod 1024=576.
  - With OMS_ACC_SATURATE_EN: acc_out=1023 and acc_sat=1.
- Async reset asserted mid-cycle during ACCUM, and N_TERMS=1 streaming -> outputs clear immediately on reset; with N_TERMS=1, each accept yields out_valid the next cycle with acc_out=mult, and continuous streaming runs at full rate.
